// File: rtl/fifo_ms_pkg.sv
// fifo_ms_pkg: shared types and helpers for the multi-stream tagged FIFO
package fifo_ms_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic int tag_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] tag_of(input logic [31:0] d, input int width, input int tw);
    return (d >> (width - tw)) & ((32'd1 << tw) - 32'd1);
  endfunction
endpackage

// File: rtl/fifo_ms_rr_pick.sv
// fifo_ms_rr_pick: rotate-priority picker, first requester after last wins
module fifo_ms_rr_pick #(
  parameter int FLUX = 2,
  parameter int TAG_W = 1
) (
  input  logic [FLUX-1:0]  req,
  input  logic [TAG_W-1:0] last,
  output logic             found,
  output logic [TAG_W-1:0] idx
);
  logic [TAG_W-1:0] c;
  // scan from farthest to nearest so the nearest requester is written last
  always_comb begin
    found = 1'b0;
    idx = '0;
    c = '0;
    for (int k = FLUX; k >= 1; k--) begin
      c = TAG_W'((int'(last) + k) % FLUX);
      if (req[c]) begin
        found = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/fifo_ms_rd_sched.sv
// fifo_ms_rd_sched: weighted round-robin read scheduler with a valid/ready output register
module fifo_ms_rd_sched
  import fifo_ms_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FLUX = 2,
  parameter int W_W = 4,
  parameter int TAG_W = tag_w(FLUX)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [FLUX-1:0]  fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic [FLUX-1:0]  fifo_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  input  logic             cfg_we,
  input  logic [TAG_W-1:0] cfg_idx,
  input  logic [W_W-1:0]   cfg_weight,
  output logic             grant_valid,
  output logic [TAG_W-1:0] grant_idx,
  output logic             tag_err
);
  state_t state, state_nx;
  logic [TAG_W-1:0] last, pick;
  logic [W_W-1:0] quota;
  logic [W_W-1:0] weight [FLUX];
  logic [FLUX-1:0] elig;
  logic found, space, rd;
  always_comb
    for (int i = 0; i < FLUX; i++) elig[i] = !fifo_empty[i] && weight[i] != '0;
  fifo_ms_rr_pick #(.FLUX(FLUX), .TAG_W(TAG_W)) u_pick (
    .req(elig),
    .last(last),
    .found(found),
    .idx(pick)
  );
  assign space = !out_valid || out_ready;
  assign grant_valid = state == BURST;
  // reset gates the strobe so a word is never popped into a register being cleared
  always_comb begin
    state_nx = state;
    rd = 1'b0;
    fifo_rd = '0;
    if (state == IDLE) state_nx = found ? BURST : IDLE;
    else begin
      rd = !rst && space && !fifo_empty[grant_idx];
      fifo_rd = rd ? FLUX'(1) << grant_idx : '0;
      state_nx = (fifo_empty[grant_idx] || (rd && quota == W_W'(1))) ? IDLE : BURST;
    end
  end
  always_ff @(posedge ck) state <= rst ? IDLE : state_nx;
  always_ff @(posedge ck) begin
    if (rst) begin
      grant_idx <= '0;
      quota <= '0;
      last <= TAG_W'(FLUX - 1);
      out_valid <= 1'b0;
      out_data <= '0;
      out_tag <= '0;
      tag_err <= 1'b0;
      for (int i = 0; i < FLUX; i++) weight[i] <= W_W'(1);
    end else begin
      if (state == IDLE && found) begin
        grant_idx <= pick;
        quota <= weight[pick];
        last <= pick;
      end
      if (rd) begin
        quota <= quota - W_W'(1);
        out_data <= fifo_dout;
        out_tag <= grant_idx;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
      if (rd && tag_of(32'(fifo_dout), WIDTH, TAG_W) != 32'(grant_idx)) tag_err <= 1'b1;
      if (cfg_we && int'(cfg_idx) < FLUX) weight[cfg_idx] <= cfg_weight;
    end
  end
endmodule

// File: tb/tb_fifo_ms_rd_sched.sv
// tb_fifo_ms_rd_sched: scoreboard bench with a two-stream show-ahead FIFO model
module tb_fifo_ms_rd_sched;
  localparam int WIDTH = 8, FLUX = 2, W_W = 4, TAG_W = 1;
  localparam logic [1:0] WRR_SEQ [11] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00,
                                          2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
  logic ck = 1'b0, rst;
  logic [FLUX-1:0] fifo_empty, fifo_rd;
  logic [WIDTH-1:0] fifo_dout, out_data;
  logic out_valid, out_ready, cfg_we, grant_valid, tag_err;
  logic [TAG_W-1:0] out_tag, cfg_idx, grant_idx;
  logic [W_W-1:0] cfg_weight;
  int cnt [2];
  logic [6:0] seq [2];
  logic bad_tag;
  logic [8:0] sb [$];
  logic [1:0] last_rd;
  int tests = 0, fails = 0;

  fifo_ms_rd_sched #(.WIDTH(WIDTH), .FLUX(FLUX), .W_W(W_W), .TAG_W(TAG_W)) dut (
    .ck(ck), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_weight(cfg_weight),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .tag_err(tag_err)
  );

  always #5 ck = ~ck;
  always_comb begin
    fifo_empty = '0;
    for (int i = 0; i < 2; i++) fifo_empty[i] = cnt[i] == 0;
  end
  always_comb fifo_dout = fifo_rd[1] ? {~bad_tag, seq[1]} : {bad_tag, seq[0]};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // one clock of traffic: legality check, scoreboard pop/push, FIFO model update
  task automatic cycle();
    logic [8:0] exp;
    #1;
    last_rd = fifo_rd;
    tests++;
    if ((fifo_rd & fifo_empty) != 0 || fifo_rd == 2'b11 || (fifo_rd != 0 && out_valid && !out_ready)) begin
      fails++;
      $display("FAIL rd_legal: fifo_rd=%b empty=%b out_valid=%b out_ready=%b", fifo_rd, fifo_empty, out_valid, out_ready);
    end
    if (out_valid && out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_pop: got tag=%0d data=%h, expected no word", out_tag, out_data);
      end else begin
        exp = sb.pop_front();
        if ({out_tag, out_data} !== exp) begin
          fails++;
          $display("FAIL sb_word: got tag=%0d data=%h, expected tag=%0d data=%h", out_tag, out_data, exp[8], exp[7:0]);
        end
      end
    end
    if (fifo_rd[0]) sb.push_back({1'b0, bad_tag, seq[0]});
    if (fifo_rd[1]) sb.push_back({1'b1, ~bad_tag, seq[1]});
    @(posedge ck);
    #1;
    for (int i = 0; i < 2; i++) if (last_rd[i]) begin cnt[i]--; seq[i]++; end
    @(negedge ck);
  endtask

  task automatic apply_reset();
    rst = 1'b1; cfg_we = 1'b0; out_ready = 1'b1; bad_tag = 1'b0;
    cnt[0] = 0; cnt[1] = 0;
    repeat (2) @(posedge ck);
    @(negedge ck);
    sb.delete();
    seq[0] = 7'h10; seq[1] = 7'h20;
    rst = 1'b0;
  endtask

  task automatic set_weight(input logic [TAG_W-1:0] idx, input logic [W_W-1:0] w);
    cfg_we = 1'b1; cfg_idx = idx; cfg_weight = w;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge ck);
    @(negedge ck);
    #1;
    tests += 6;
    if (fifo_rd !== 2'b00) begin fails++; $display("FAIL rst_rd: got %b expected 00", fifo_rd); end
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    if (tag_err !== 1'b0) begin fails++; $display("FAIL rst_tag_err: got %b expected 0", tag_err); end
    if (grant_valid !== 1'b0) begin fails++; $display("FAIL rst_grant: got %b expected 0", grant_valid); end
    if (out_data !== 8'h00) begin fails++; $display("FAIL rst_data: got %h expected 00", out_data); end
    if (out_tag !== 1'b0) begin fails++; $display("FAIL rst_tag: got %0d expected 0", out_tag); end
    rst = 1'b0;
    @(negedge ck);
    #1;
    tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 1'b0) begin
      fails++;
      $display("FAIL first_grant: got valid=%b idx=%0d expected valid=1 idx=0", grant_valid, grant_idx);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (fifo_rd !== 2'b00) begin fails++; $display("FAIL rst_mid_rd: got %b expected 00", fifo_rd); end
    @(posedge ck);
    #1;
    tests++;
    if (out_valid !== 1'b0 || grant_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_drop: got out_valid=%b grant_valid=%b expected 0 0", out_valid, grant_valid);
    end
    @(negedge ck);
  endtask

  task automatic test_wrr();
    int n = 0;
    bit started = 0;
    apply_reset();
    set_weight(1'b0, 4'd3);
    cnt[0] = 10; cnt[1] = 10;
    for (int c = 0; c < 40 && n < 11; c++) begin
      cycle();
      if (last_rd != 0) started = 1;
      if (started) begin
        tests++;
        if (last_rd !== WRR_SEQ[n]) begin
          fails++;
          $display("FAIL wrr_seq[%0d]: got %b expected %b", n, last_rd, WRR_SEQ[n]);
        end
        n++;
      end
    end
    tests++;
    if (n != 11) begin fails++; $display("FAIL wrr_timeout: got %0d reads logged expected 11", n); end
    repeat (3) cycle();
    tests++;
    if (tag_err !== 1'b0) begin fails++; $display("FAIL wrr_tag_err: got %b expected 0", tag_err); end
  endtask

  task automatic test_backpressure();
    int reads = 0;
    bit got = 0;
    apply_reset();
    set_weight(1'b0, 4'd4);
    cnt[0] = 4;
    for (int c = 0; c < 10 && !got; c++) begin
      cycle();
      got = last_rd != 0;
    end
    tests++;
    if (!got) begin fails++; $display("FAIL bp_first: got no read expected one within 10 cycles"); end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (last_rd != 0) reads++;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h10) begin
        fails++;
        $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=10", out_valid, out_data);
      end
    end
    tests++;
    if (reads != 0) begin fails++; $display("FAIL bp_reads: got %0d expected 0", reads); end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      tests++;
      if (last_rd !== 2'b01) begin fails++; $display("FAIL bp_resume[%0d]: got %b expected 01", c, last_rd); end
    end
    repeat (4) cycle();
    tests++;
    if (sb.size() != 0 || grant_valid !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain: got pending=%0d grant=%b valid=%b expected 0 0 0", sb.size(), grant_valid, out_valid);
    end
  endtask

  task automatic test_empty_mid();
    int reads = 0, run = 0;
    bit started = 0, done = 0;
    apply_reset();
    set_weight(1'b1, 4'd5);
    cnt[1] = 2;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (last_rd == 2'b10) reads++;
    end
    tests++;
    if (reads != 2 || grant_valid !== 1'b0) begin
      fails++;
      $display("FAIL empty_mid: got reads=%0d grant=%b expected reads=2 grant=0", reads, grant_valid);
    end
    cnt[1] = 10;
    for (int c = 0; c < 20 && !done; c++) begin
      cycle();
      if (last_rd == 2'b10) begin started = 1; run++; end
      else if (started) done = 1;
    end
    tests++;
    if (run != 5) begin fails++; $display("FAIL empty_requota: got burst=%0d expected 5", run); end
  endtask

  task automatic test_disable();
    int r0 = 0, r1 = 0;
    apply_reset();
    set_weight(1'b0, 4'd0);
    cnt[0] = 10; cnt[1] = 10;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (last_rd[0]) r0++;
      if (last_rd[1]) r1++;
    end
    tests++;
    if (r0 != 0 || r1 != 10) begin fails++; $display("FAIL disable: got r0=%0d r1=%0d expected 0 10", r0, r1); end
    set_weight(1'b0, 4'd2);
    cnt[1] = 10;
    r0 = 0; r1 = 0;
    for (int c = 0; c < 15; c++) begin
      cycle();
      if (last_rd[0]) r0++;
      if (last_rd[1]) r1++;
    end
    tests++;
    if (r0 == 0 || r1 == 0) begin fails++; $display("FAIL reenable: got r0=%0d r1=%0d expected both nonzero", r0, r1); end
    repeat (4) cycle();
  endtask

  task automatic test_tag();
    apply_reset();
    bad_tag = 1'b1;
    cnt[1] = 1;
    cycle();
    tests++;
    if (tag_err !== 1'b0) begin fails++; $display("FAIL tag_pre: got %b expected 0", tag_err); end
    cycle();
    tests++;
    if (last_rd !== 2'b10 || tag_err !== 1'b1) begin
      fails++;
      $display("FAIL tag_set: got rd=%b tag_err=%b expected 10 1", last_rd, tag_err);
    end
    repeat (5) cycle();
    tests++;
    if (tag_err !== 1'b1) begin fails++; $display("FAIL tag_sticky: got %b expected 1", tag_err); end
    apply_reset();
    #1;
    tests++;
    if (tag_err !== 1'b0) begin fails++; $display("FAIL tag_clear: got %b expected 0", tag_err); end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0; bad_tag = 1'b0;
    cnt[0] = 2; cnt[1] = 2; seq[0] = 7'h10; seq[1] = 7'h20;
    @(negedge ck);
    test_reset();
    test_wrr();
    test_backpressure();
    test_empty_mid();
    test_disable();
    test_tag();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
